svm_dag_sequencer: RTL and testbench



---
 rtl/svm_seq_pkg.sv | 30 +++
 rtl/svm_mac_unit.sv | 63 ++++++
 rtl/svm_dag_sequencer.sv | 126 ++++++++++++
 tb/tb_svm_dag_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svm_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : svm_seq_pkg
//  Brief   : Shared types and index helpers for the one-vs-one SVM DAG sequencer.
//  Revision: 1.0 - initial release
// ============================================================================
package svm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        MAC    = 2'd2,
        DECIDE = 2'd3
    } state_t;

    function automatic int n_pairs(input int n);
        return (n * (n - 1)) / 2;
    endfunction

    // Row-major position of pair (lo,hi) in the upper-triangular classifier table.
    function automatic int clf_index(input int lo, input int hi, input int n);
        return lo * (n - 1) - (lo * (lo - 1)) / 2 + (n - 1 - hi);
    endfunction

    function automatic int clf_width(input int n);
        return (n_pairs(n) > 1) ? $clog2(n_pairs(n)) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/svm_mac_unit.sv
`default_nettype none
// ============================================================================
//  Module  : svm_mac_unit
//  Brief   : Feature-serial signed MAC accumulator; SVM_ACC_SAT_EN saturates
//            every load/add, otherwise the accumulator wraps.
//  Revision: 1.0 - initial release
// ============================================================================
module svm_mac_unit #(
    parameter int FEAT_W   = 4,
    parameter int WEIGHT_W = 8,
    parameter int BIAS_W   = 16,
    parameter int ACC_W    = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       en,
    input  logic signed [BIAS_W-1:0]   bias,
    input  logic        [FEAT_W-1:0]   feat,
    input  logic signed [WEIGHT_W-1:0] weight,
    output logic signed [ACC_W-1:0]    acc
);

    localparam int c_PROD_W = FEAT_W + 1 + WEIGHT_W;
`ifdef SVM_ACC_SAT_EN
    localparam int c_WIDE_W = (ACC_W > c_PROD_W) ? ACC_W : c_PROD_W;
    localparam int c_SUM_W  = ((c_WIDE_W > BIAS_W) ? c_WIDE_W : BIAS_W) + 1;
`else
    localparam int c_SUM_W  = ACC_W;
`endif

    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_SUM_W-1:0]  w_base;
    logic signed [c_SUM_W-1:0]  w_addend;
    logic signed [c_SUM_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]    w_next;

    assign w_prod   = c_PROD_W'($signed({1'b0, feat})) * c_PROD_W'(weight);
    assign w_base   = load ? '0 : c_SUM_W'(acc);
    assign w_addend = load ? c_SUM_W'(bias) : c_SUM_W'(w_prod);
    assign w_sum    = w_base + w_addend;

`ifdef SVM_ACC_SAT_EN
    // Sum fits when every bit above the ACC_W sign bit agrees with it.
    logic w_ovf;
    assign w_ovf  = !((&w_sum[c_SUM_W-1:ACC_W-1]) || !(|w_sum[c_SUM_W-1:ACC_W-1]));
    assign w_next = !w_ovf ? w_sum[ACC_W-1:0]
                  : (w_sum[c_SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}});
`else
    assign w_next = w_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (load || en) begin
            acc <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/svm_dag_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : svm_dag_sequencer
//  Brief   : One-vs-one SVM DAG classifier controller on a shared serial MAC.
//            Optional macro SVM_ACC_SAT_EN enables accumulator saturation.
//  Revision: 1.0 - initial release
// ============================================================================
module svm_dag_sequencer
    import svm_seq_pkg::*;
#(
    parameter int N_CLASSES  = 10,
    parameter int N_FEATURES = 16,
    parameter int FEAT_W     = 4,
    parameter int WEIGHT_W   = 8,
    parameter int BIAS_W     = 16,
    parameter int ACC_W      = 20,
    parameter int CLF_W      = clf_width(N_CLASSES),
    parameter int WIN_W      = $clog2(N_CLASSES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [N_FEATURES*FEAT_W-1:0]   features,
    output logic [CLF_W-1:0]               clf_idx,
    input  logic [N_FEATURES*WEIGHT_W-1:0] weight_row,
    input  logic [BIAS_W-1:0]              bias,
    output logic                           busy,
    output logic                           done,
    output logic [WIN_W-1:0]               winner,
    output logic [ACC_W-1:0]               score
);

    localparam int c_K_W = (N_FEATURES > 1) ? $clog2(N_FEATURES) : 1;

    state_t                         r_state;
    logic [N_FEATURES*FEAT_W-1:0]   r_feat;
    logic [WIN_W-1:0]               r_lo;
    logic [WIN_W-1:0]               r_hi;
    logic [c_K_W-1:0]               r_k;

    logic [FEAT_W-1:0]              w_feat;
    logic signed [WEIGHT_W-1:0]     w_weight;
    logic signed [ACC_W-1:0]        w_acc;
    logic                           w_keep_lo;
    logic [WIN_W-1:0]               w_lo_n;
    logic [WIN_W-1:0]               w_hi_n;

    assign w_feat    = r_feat[int'(r_k)*FEAT_W +: FEAT_W];
    assign w_weight  = $signed(weight_row[int'(r_k)*WEIGHT_W +: WEIGHT_W]);
    // A score of exactly zero counts as a vote for the low class.
    assign w_keep_lo = !w_acc[ACC_W-1];
    assign w_lo_n    = w_keep_lo ? r_lo : r_lo + WIN_W'(1);
    assign w_hi_n    = w_keep_lo ? r_hi - WIN_W'(1) : r_hi;

    svm_mac_unit #(
        .FEAT_W   (FEAT_W),
        .WEIGHT_W (WEIGHT_W),
        .BIAS_W   (BIAS_W),
        .ACC_W    (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .load   (r_state == LOAD),
        .en     (r_state == MAC),
        .bias   ($signed(bias)),
        .feat   (w_feat),
        .weight (w_weight),
        .acc    (w_acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_feat  <= '0;
            r_lo    <= '0;
            r_hi    <= WIN_W'(N_CLASSES - 1);
            r_k     <= '0;
            clf_idx <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            winner  <= '0;
            score   <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_feat  <= features;
                        r_lo    <= '0;
                        r_hi    <= WIN_W'(N_CLASSES - 1);
                        clf_idx <= CLF_W'(clf_index(0, N_CLASSES - 1, N_CLASSES));
                        busy    <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_k     <= '0;
                    r_state <= MAC;
                end
                MAC: begin
                    r_k <= r_k + c_K_W'(1);
                    if (r_k == c_K_W'(N_FEATURES - 1)) begin
                        r_state <= DECIDE;
                    end
                end
                DECIDE: begin
                    score <= w_acc;
                    r_lo  <= w_lo_n;
                    r_hi  <= w_hi_n;
                    if (w_lo_n == w_hi_n) begin
                        winner  <= w_lo_n;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        clf_idx <= CLF_W'(clf_index(int'(w_lo_n), int'(w_hi_n), N_CLASSES));
                        r_state <= LOAD;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_svm_dag_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_svm_dag_sequencer
//  Brief   : Self-checking bench: DAG walk model with scoreboard queues, plus
//            small-parameter instances for the arithmetic corner cases.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_svm_dag_sequencer;

    localparam int N   = 10;
    localparam int NF  = 16;
    localparam int FW  = 4;
    localparam int WW  = 8;
    localparam int BW  = 16;
    localparam int AW  = 20;
    localparam int LAT = (N - 1) * (NF + 2) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance
    logic            start;
    logic [NF*FW-1:0] features;
    logic [5:0]      clf_idx;
    logic [NF*WW-1:0] weight_row;
    logic [BW-1:0]   bias;
    logic            busy, done;
    logic [3:0]      winner;
    logic [AW-1:0]   score;

    svm_dag_sequencer #(
        .N_CLASSES(N), .N_FEATURES(NF), .FEAT_W(FW), .WEIGHT_W(WW), .BIAS_W(BW), .ACC_W(AW)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .features(features), .clf_idx(clf_idx),
        .weight_row(weight_row), .bias(bias), .busy(busy), .done(done),
        .winner(winner), .score(score)
    );

    // Three-class, two-feature instance
    logic        start_s;
    logic [7:0]  features3;
    logic [1:0]  clf_idx3;
    logic [15:0] weight_row3;
    logic [15:0] bias3;
    logic        busy3, done3;
    logic [1:0]  winner3;
    logic [19:0] score3;

    svm_dag_sequencer #(
        .N_CLASSES(3), .N_FEATURES(2), .FEAT_W(4), .WEIGHT_W(8), .BIAS_W(16), .ACC_W(20)
    ) u_dut3 (
        .clk(clk), .rst(rst), .start(start_s), .features(features3), .clf_idx(clf_idx3),
        .weight_row(weight_row3), .bias(bias3), .busy(busy3), .done(done3),
        .winner(winner3), .score(score3)
    );

    // Two-class instance with a narrow accumulator
    logic [7:0]  features2;
    logic [0:0]  clf_idx2;
    logic [15:0] weight_row2;
    logic [7:0]  bias2;
    logic        busy2, done2;
    logic [0:0]  winner2;
    logic [11:0] score2;

    svm_dag_sequencer #(
        .N_CLASSES(2), .N_FEATURES(2), .FEAT_W(4), .WEIGHT_W(8), .BIAS_W(8), .ACC_W(12)
    ) u_dut2 (
        .clk(clk), .rst(rst), .start(start_s), .features(features2), .clf_idx(clf_idx2),
        .weight_row(weight_row2), .bias(bias2), .busy(busy2), .done(done2),
        .winner(winner2), .score(score2)
    );

    assign features3   = {4'd3, 4'd15};
    assign weight_row3 = (clf_idx3 == 2'd0) ? {8'sd5, -8'sd128} : 16'h0000;
    assign bias3       = 16'h0000;
    assign features2   = {4'd15, 4'd15};
    assign weight_row2 = {8'sd127, 8'sd127};
    assign bias2       = 8'h00;

    // Coefficient ROM for the main instance
    int mode = 0;

    function automatic int rom_w(input int idx, input int k);
        return (mode == 2) ? ((idx * 37 + k * 11 + 5) % 256) - 128 : 0;
    endfunction

    function automatic int rom_b(input int idx);
        if (mode == 0) return 1;
        if (mode == 1) return -1;
        return ((idx * 101 + 13) % 512) - 256;
    endfunction

    always_comb begin
        weight_row = '0;
        for (int k = 0; k < NF; k++) weight_row[k*WW +: WW] = WW'(rom_w(int'(clf_idx), k));
        bias = BW'(rom_b(int'(clf_idx)));
    end

    // Scoreboard
    int     checks = 0;
    int     errors = 0;
    int     exp_idx[$];
    int     exp_win[$];
    longint exp_score[$];
    int     exp_cyc[$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint norm(input longint v);
`ifdef SVM_ACC_SAT_EN
        longint hi_lim = (longint'(1) <<< (AW - 1)) - 1;
        longint lo_lim = -(longint'(1) <<< (AW - 1));
        if (v > hi_lim) return hi_lim;
        if (v < lo_lim) return lo_lim;
        return v;
`else
        longint m = v & ((longint'(1) <<< AW) - 1);
        if (m >= (longint'(1) <<< (AW - 1))) m = m - (longint'(1) <<< AW);
        return m;
`endif
    endfunction

    task automatic push_run(input logic [NF*FW-1:0] f, input int t0);
        int lo = 0;
        int hi = N - 1;
        int idx;
        longint acc = 0;
        while (lo != hi) begin
            idx = lo * (N - 1) - (lo * (lo - 1)) / 2 + (N - 1 - hi);
            exp_idx.push_back(idx);
            acc = norm(longint'(rom_b(idx)));
            for (int k = 0; k < NF; k++)
                acc = norm(acc + longint'(f[k*FW +: FW]) * longint'(rom_w(idx, k)));
            if (acc >= 0) hi--; else lo++;
        end
        exp_win.push_back(lo);
        exp_score.push_back(acc);
        exp_cyc.push_back(t0 + LAT);
    endtask

    // Monitor: every new ROM address and every done pulse is checked against the queues.
    logic       prev_busy = 1'b0;
    logic [5:0] prev_idx  = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && (!prev_busy || clf_idx != prev_idx)) begin
                if (exp_idx.size() == 0) chk("clf_idx_extra", longint'(clf_idx), -1);
                else chk("clf_idx", longint'(clf_idx), longint'(exp_idx.pop_front()));
            end
            if (done) begin
                if (exp_win.size() == 0) begin
                    chk("done_unexpected", longint'(done), 0);
                end else begin
                    chk("winner", longint'(winner), longint'(exp_win.pop_front()));
                    chk("score", longint'($signed(score)), exp_score.pop_front());
                    chk("done_cycle", longint'(cyc), longint'(exp_cyc.pop_front()));
                end
            end
        end
        prev_busy = busy;
        prev_idx  = clf_idx;
    end

    task automatic launch(input logic [NF*FW-1:0] f);
        features = f;
        start    = 1'b1;
        push_run(f, cyc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            if (exp_win.size() == 0) break;
            @(negedge clk);
        end
        chk("done_timeout", longint'(exp_win.size()), 0);
    endtask

    initial begin
        start    = 1'b0;
        start_s  = 1'b0;
        features = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_winner", longint'(winner), 0);
        chk("rst_score", longint'(score), 0);
        chk("rst_clf_idx", longint'(clf_idx), 0);
        chk("rst_busy_small", longint'({busy3, busy2, clf_idx2}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Zero weights, positive bias: low class always kept
        mode = 0;
        launch(64'h0123_4567_89AB_CDEF);
        wait_done();

        // Ignored start at cycle 50, then back-to-back start in the done cycle
        mode = 2;
        launch(64'hFEDC_BA98_7654_3210);
        repeat (49) @(negedge clk);
        features = 64'h0F0F_0F0F_F0F0_F0F0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen_for_restart", longint'(done), 1);
        launch(64'h3C5A_A5C3_9E17_71E9);
        wait_done();

        // Zero weights, negative bias: high class always kept
        mode = 1;
        launch(64'h0123_4567_89AB_CDEF);
        wait_done();

        // Reset in cycle 80 of a run
        launch(64'h0123_4567_89AB_CDEF);
        repeat (79) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_clf_idx", longint'(clf_idx), 0);
        chk("midrst_winner", longint'(winner), 0);
        chk("midrst_done", longint'(done), 0);
        chk("midrst_score", longint'(score), 0);
        exp_idx.delete();
        exp_win.delete();
        exp_score.delete();
        exp_cyc.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);

        mode = 2;
        launch(64'h0F0F_0F0F_F0F0_F0F0);
        wait_done();

        // Small instances
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        repeat (3) @(negedge clk);
        chk("n2_done_early", longint'(done2), 0);
        @(negedge clk);
        chk("n3_first_score", longint'($signed(score3)), -1905);
        chk("n3_second_idx", longint'(clf_idx3), 2);
        chk("n2_done", longint'(done2), 1);
`ifdef SVM_ACC_SAT_EN
        chk("n2_score", longint'($signed(score2)), 2047);
        chk("n2_winner", longint'(winner2), 0);
`else
        chk("n2_score", longint'($signed(score2)), -286);
        chk("n2_winner", longint'(winner2), 1);
`endif
        repeat (3) @(negedge clk);
        chk("n3_done_early", longint'(done3), 0);
        @(negedge clk);
        chk("n3_done", longint'(done3), 1);
        chk("n3_winner", longint'(winner3), 1);
        chk("n3_final_score", longint'($signed(score3)), 0);

        repeat (5) @(negedge clk);
        chk("idx_queue_drained", longint'(exp_idx.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
